priority_grant_sequencer: RTL

PRIORITY_GRANT_SEQUENCER -- requirements
Module: priority_grant_sequencer

---
 rtl/priority_grant_sequencer_if.sv | 27 ++
 rtl/priority_grant_sequencer.sv | 92 +++++++++
 2 files changed

// File: rtl/priority_grant_sequencer_if.sv
// rtl/priority_grant_sequencer_if.sv - request, encoder and grant handshake bundle
interface priority_grant_sequencer_if #(
   parameter int REQ_WIDTH = 12,
   parameter int IDX_W     = $clog2(REQ_WIDTH)
);
   logic [REQ_WIDTH-1:0] req_set;
   logic [REQ_WIDTH-1:0] pend;
   logic [IDX_W-1:0]     first;
   logic [IDX_W-1:0]     second;
   logic                 gnt_valid;
   logic [IDX_W-1:0]     gnt_idx;
   logic                 gnt_last;
   logic                 gnt_ready;
   logic                 busy;

   // Sequencer side: takes requests and encoder results, offers grants
   modport master (
      input  req_set, first, second, gnt_ready,
      output pend, gnt_valid, gnt_idx, gnt_last, busy
   );

   // Environment side: raises requests, encodes pend, accepts grants
   modport slave (
      output req_set, first, second, gnt_ready,
      input  pend, gnt_valid, gnt_idx, gnt_last, busy
   );
endinterface

// File: rtl/priority_grant_sequencer.sv
// rtl/priority_grant_sequencer.sv - grants the top two pending requests per batch
module priority_grant_sequencer #(
   parameter int REQ_WIDTH = 12,
   parameter int IDX_W     = $clog2(REQ_WIDTH)
) (
   input  logic                          clk,
   input  logic                          reset_n,
   priority_grant_sequencer_if.master    bus
);

   typedef enum logic [1:0] {IDLE, GRANT1, GRANT2} state_t;

   state_t               state_q;
   state_t               state_d;
   logic [REQ_WIDTH-1:0] pend_q;
   logic [REQ_WIDTH-1:0] clr_mask;
   logic [IDX_W-1:0]     idx_a;
   logic [IDX_W-1:0]     idx_b;
   logic                 pair;
   logic                 load;
   logic                 gnt_valid;
   logic [IDX_W-1:0]     gnt_idx;
   logic                 gnt_last;

   assign bus.pend      = pend_q;
   assign bus.gnt_valid = gnt_valid;
   assign bus.gnt_idx   = gnt_idx;
   assign bus.gnt_last  = gnt_last;
   assign bus.busy      = (state_q != IDLE);

   // State register and pending vector; a new request beats a same-cycle clear
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         pend_q  <= '0;
      end else begin
         state_q <= state_d;
         pend_q  <= (pend_q & ~clr_mask) | bus.req_set;
      end
   end

   // Batch latch: encoder results are captured only when leaving IDLE
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         idx_a <= '0;
         idx_b <= '0;
         pair  <= 1'b0;
      end else if (load) begin
         idx_a <= bus.first;
         idx_b <= bus.second;
         pair  <= |(pend_q & (pend_q - REQ_WIDTH'(1)));
      end
   end

   // Next state, grant outputs and the pend clear mask for accepted grants
   always_comb begin
      state_d   = state_q;
      load      = 1'b0;
      clr_mask  = '0;
      gnt_valid = 1'b0;
      gnt_idx   = '0;
      gnt_last  = 1'b0;
      case (state_q)
         IDLE: begin
            if (pend_q != '0) begin
               load    = 1'b1;
               state_d = GRANT1;
            end
         end
         GRANT1: begin
            gnt_valid = 1'b1;
            gnt_idx   = idx_a;
            gnt_last  = !pair;
            if (bus.gnt_ready) begin
               clr_mask = REQ_WIDTH'(1) << idx_a;
               state_d  = pair ? GRANT2 : IDLE;
            end
         end
         GRANT2: begin
            gnt_valid = 1'b1;
            gnt_idx   = idx_b;
            gnt_last  = 1'b1;
            if (bus.gnt_ready) begin
               clr_mask = REQ_WIDTH'(1) << idx_b;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule
